// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a registered-read memory, with valid/ready on both ends.
// A two-entry output buffer (out + skid) prefetches so the output sustains one word per clock.
module mem_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int CWIDTH = $clog2(DEPTH + 3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0]  mem_wr_data,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic [CWIDTH-1:0] count
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   MEM_FULL  = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   mem_count;
    logic              rd_pending;
    logic              skid_valid;
    logic [WIDTH-1:0]  skid_data;
    logic              pop;
    logic              wr_fire;
    logic              rd_fire;
    logic [2:0]        buf_after;

    // buf_after: buffer words plus the pending return, net of this cycle's pop;
    // issuing only below 2 guarantees the returned word always has a free slot.
    always_comb begin
        pop       = out_valid && out_ready;
        in_ready  = rst_n && (mem_count < MEM_FULL);
        wr_fire   = in_valid && in_ready;
        buf_after = 3'(out_valid) + 3'(skid_valid) + 3'(rd_pending) - 3'(pop);
        rd_fire   = (mem_count != '0) && (buf_after < 3'd2);
    end

    always_comb begin
        mem_wr_en   = wr_fire;
        mem_wr_addr = wr_ptr;
        mem_wr_data = in_data;
        mem_rd_en   = rd_fire;
        mem_rd_addr = rd_ptr;
        count       = CWIDTH'(mem_count) + CWIDTH'(rd_pending)
                    + CWIDTH'(out_valid) + CWIDTH'(skid_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            rd_pending <= rd_fire;
            case ({wr_fire, rd_fire})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop && skid_valid) begin
            out_data <= skid_data;
            if (rd_pending) begin
                skid_data <= mem_rd_data;
            end else begin
                skid_valid <= 1'b0;
            end
        end else if (rd_pending) begin
            // pop here implies skid is empty, so the return goes straight to out
            if (!out_valid || pop) begin
                out_data  <= mem_rd_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= mem_rd_data;
                skid_valid <= 1'b1;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a registered-read memory model attached.
module tb_mem_fifo_ctrl;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 32;
    localparam int AWIDTH = 3;
    localparam int CWIDTH = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              mem_wr_en;
    logic [AWIDTH-1:0] mem_wr_addr;
    logic [WIDTH-1:0]  mem_wr_data;
    logic              mem_rd_en;
    logic [AWIDTH-1:0] mem_rd_addr;
    logic [WIDTH-1:0]  mem_rd_data;
    logic [CWIDTH-1:0] count;

    logic [WIDTH-1:0]  mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int sent;
    int rcv;
    int accepted;
    int cnt_m;
    int wraps;
    logic [AWIDTH-1:0] wr_m;
    logic [AWIDTH-1:0] rd_m;
    logic [WIDTH-1:0]  q[$];

    mem_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_rd_data = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD0000;
        out_ready = 1'b0;

        // reset state with a producer already asserting valid
        #3;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_count", count, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_wr_en", mem_wr_en, 0);
        check_val("rst_rd_en", mem_rd_en, 0);
        check_val("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        #1;
        check_val("rel_in_ready", in_ready, 1);

        // single word latency
        in_valid = 1'b1;
        in_data  = 32'hA5A50001;
        #1;
        check_val("sw_wr_en", mem_wr_en, 1);
        check_val("sw_wr_addr", mem_wr_addr, 0);
        check_val("sw_wr_data", mem_wr_data, 32'hA5A50001);
        tick();
        in_valid = 1'b0;
        #1;
        check_val("sw_rd_en", mem_rd_en, 1);
        check_val("sw_rd_addr", mem_rd_addr, 0);
        check_val("sw_count_e1", count, 1);
        tick();
        #1;
        check_val("sw_valid_e2", out_valid, 0);
        check_val("sw_count_e2", count, 1);
        tick();
        #1;
        check_val("sw_valid", out_valid, 1);
        check_val("sw_data", out_data, 32'hA5A50001);
        check_val("sw_count", count, 1);
        tick();
        #1;
        check_val("sw_hold_data", out_data, 32'hA5A50001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check_val("sw_drained", out_valid, 0);
        check_val("sw_count0", count, 0);

        // fill until full with consumer stalled
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            #1;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check_val("fill_accepted", accepted, 10);
        check_val("fill_in_ready", in_ready, 0);
        check_val("fill_count", count, 10);

        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_val("drain_valid", out_valid, 1);
            check_val("drain_data", out_data, 32'(k));
            check_val("drain_count", count, 32'(10 - k));
            tick();
        end
        #1;
        check_val("drain_empty", out_valid, 0);
        check_val("drain_count0", count, 0);

        // continuous streaming, no bubbles after startup
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 104; c++) begin
            in_valid  = (sent < 100);
            in_data   = 32'h1000 + 32'(sent);
            out_ready = 1'b1;
            #1;
            if (c >= 3 && c <= 102) check_val("stream_valid", out_valid, 1);
            if (c == 103) check_val("stream_idle", out_valid, 0);
            if (out_valid) begin
                check_val("stream_data", out_data, 32'h1000 + 32'(rcv));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check_val("stream_total", rcv, 100);

        // random backpressure with address wrap; 111 prior writes leave both pointers at 7
        sent  = 0;
        rcv   = 0;
        cnt_m = 0;
        wraps = 0;
        wr_m  = 3'd7;
        rd_m  = 3'd7;
        for (int c = 0; c < 2000 && rcv < 24; c++) begin
            in_valid  = (sent < 24) && ($urandom_range(0, 1) == 1);
            in_data   = 32'hC0DE0000 + 32'(sent);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            check_val("rand_count", count, cnt_m);
            if (mem_wr_en) begin
                check_val("rand_wr_addr", mem_wr_addr, wr_m);
                if (mem_wr_addr == 3'd0) wraps++;
                wr_m = (wr_m == 3'd7) ? 3'd0 : wr_m + 3'd1;
            end
            if (mem_rd_en) begin
                check_val("rand_rd_addr", mem_rd_addr, rd_m);
                rd_m = (rd_m == 3'd7) ? 3'd0 : rd_m + 3'd1;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
                cnt_m++;
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) check_val("rand_data", out_data, q.pop_front());
                else check_val("rand_extra_pop", 32'(q.size()), 1);
                rcv++;
                cnt_m--;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("rand_done", rcv, 24);
        check_val("rand_wraps", wraps, 3);

        // mid-operation reset with a read in flight
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hBEEF0000 + 32'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("mr_head", out_data, 32'hBEEF0000);
        check_val("mr_rd_issue", mem_rd_en, 1);
        tick();
        out_ready = 1'b0;
        #1;
        check_val("mr_count_pre", count, 4);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h5555AAAA;
        #1;
        check_val("mr_out_valid", out_valid, 0);
        check_val("mr_count", count, 0);
        check_val("mr_in_ready", in_ready, 0);
        check_val("mr_wr_en", mem_wr_en, 0);
        check_val("mr_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 32'h00001234;
        #1;
        check_val("mr_new_addr", mem_wr_addr, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check_val("mr_no_stale", out_valid, 0);
        tick();
        tick();
        #1;
        check_val("mr_new_valid", out_valid, 1);
        check_val("mr_new_data", out_data, 32'h00001234);
        check_val("mr_new_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check_val("mr_final_empty", out_valid, 0);
        check_val("mr_final_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
Initiator-side controller that drives a generic_mem-style storage (write port, read port, read data registered one cycle after mem_rd_en) and presents it as a FIFO with valid/ready handshakes on both ends. It sits between router ingress and egress logic. It owns the pointers, occupancy and read-latency hiding. A 2-entry output buffer prefetches from memory so the output can sustain one word per clock.

Parameters:
DEPTH, 8, number of memory entries; any value >= 2; pointers wrap explicitly from DEPTH-1 to 0.
WIDTH, 32, data width in bits.
AWIDTH, $clog2(DEPTH), local; memory address width.
CWIDTH, $clog2(DEPTH+3), local; width of the count output.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  producer has a word.
in_ready  out  1  controller accepts a word; a transfer occurs when in_valid and in_ready are both high at a clk edge.
in_data  in  WIDTH  producer word.
out_valid  out  1  out_data holds the FIFO head.
out_ready  in  1  consumer takes the head; a pop occurs when out_valid and out_ready are both high.
out_data  out  WIDTH  FIFO head (registered).
mem_wr_en  out  1  memory write strobe.
mem_wr_addr  out  AWIDTH  memory write address (wr_ptr).
mem_wr_data  out  WIDTH  equals in_data.
mem_rd_en  out  1  memory read strobe.
mem_rd_addr  out  AWIDTH  memory read address (rd_ptr).
mem_rd_data  in  WIDTH  memory read data, valid in the cycle after mem_rd_en is sampled.
count  out  CWIDTH  total words held: mem_count + rd_pending + buf_count.

Behaviour:
- Registered state: wr_ptr, rd_ptr, mem_count (0..DEPTH), rd_pending (1 bit), out register with out_valid, skid register with skid_valid.
- Reset (async on rst_n low): all registers cleared, so out_valid=0, count=0 and out_data=0. While rst_n is low, in_ready=0, mem_wr_en=0 and mem_rd_en=0. Any in-flight read data is discarded.
- in_ready = rst_n && (mem_count < DEPTH).
- Memory write path:
  - mem_wr_en = in_valid && in_ready.
  - On a write, wr_ptr advances with wrap.
- Read issue:
  - buf_count = out_valid + skid_valid; pop = out_valid && out_ready.
  - mem_rd_en = (mem_count > 0) && (buf_count + rd_pending - pop < 2).
  - On a read, rd_ptr advances with wrap, and rd_pending is set for the next cycle. Otherwise rd_pending is cleared.
- mem_count update: +1 on write, -1 on read, unchanged when both occur in the same cycle.
- Read/write collision: a read never targets the slot written in the same cycle. mem_count > 0 implies rd_ptr != wr_ptr unless full, and no write is allowed when full.
- Return capture: when rd_pending is high, mem_rd_data is captured.
  - It goes to the out register if out is empty, or if out pops and skid is empty.
  - Otherwise it goes to the skid register.
- On a pop:
  - If skid is valid, skid moves to out.
  - Otherwise the returned data moves to out if rd_pending, else out_valid clears.
- Ordering is strictly FIFO. No buffered word is overwritten; this is guaranteed by the issue rule.
- Latency: on an empty FIFO, a word accepted at edge E is written at E, read issued at E+1, and out_valid/out_data are valid after edge E+2.
- Throughput: with in_valid=out_ready=1 continuously, one word per cycle in steady state with no bubbles.
- Capacity: DEPTH+2 words (memory plus output buffer). in_ready drops only when mem_count=DEPTH.
- Simultaneous push and pop at full: the pop frees a buffer slot, a read issues, mem_count drops after the edge, and in_ready rises in the next cycle. Combinational ready-from-pop is not provided.
- out_data holds its value while out_valid=1 and out_ready=0.

Test Plan:
- Reset check: assert rst_n low mid-run -> out_valid=0, count=0, in_ready=0, mem_wr_en=0, mem_rd_en=0; after release, in_ready=1.
- Single word: push 0xA5A50001 at edge E with out_ready=0 -> mem_wr_addr=0 at E, mem_rd_en with rd_addr=0 at E+1, out_valid=1 and out_data=0xA5A50001 after E+2, count=1.
- Fill/drain: out_ready=0, push 0..11 -> exactly 10 accepted (DEPTH=8), in_ready=0, count=10. Then out_ready=1 -> outputs 0..9 in order on consecutive cycles, count reaches 0.
- Streaming: in_valid=out_ready=1, push 100 incrementing words -> after the 2-cycle startup, out_valid stays high every cycle with exact sequence and no bubbles.
- Wrap/backpressure: 24 words with 50% random out_ready and 50% random in_valid -> order preserved, mem addresses wrap 7->0 three times, and count matches the model every cycle.
- Mid-operation reset: 5 words stored, one read in flight, rst_n pulsed -> old data never appears; next push 0x1234 emerges first with count=1.
